// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the 32-bit ALU sequencer:
//   - request opcodes (req_op)
//   - 16-bit ALU function encodings (alu_func)
//   - sequencer state enum
//   - small decode helpers (legality, arithmetic class, op -> ALU function)
// Optional feature macro: ALU_SEQ_SUB_EN (op 4 = SUB is legal only when defined)
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   // Request opcodes
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ANDN = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NOTB = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;

   // 16-bit ALU function encodings
   localparam logic [1:0] FUNC_ADD  = 2'b00;
   localparam logic [1:0] FUNC_ANDN = 2'b01;
   localparam logic [1:0] FUNC_OR   = 2'b10;
   localparam logic [1:0] FUNC_NOTB = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_NLO  = 3'd1,
      ST_NHI  = 3'd2,
      ST_LO   = 3'd3,
      ST_HI   = 3'd4,
      ST_RESP = 3'd5
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_SEQ_SUB_EN
      return (op <= OP_SUB);
`else
      return (op <= OP_NOTB);
`endif
   endfunction

   // Ops whose carry chain is live (carry-in used, carry-out reported)
   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // SUB runs its main passes as an add on the inverted B operand
   function automatic logic [1:0] op_func(input logic [2:0] op);
      case (op)
         OP_ANDN: return FUNC_ANDN;
         OP_OR:   return FUNC_OR;
         OP_NOTB: return FUNC_NOTB;
         default: return FUNC_ADD;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq32.sv
// -----------------------------------------------------------------------------
// alu_seq32
// Sequences 32-bit requests onto an external 16-bit combinational ALU as
// low-half then high-half passes, chaining the carry between them. SUB first
// inverts B through the ALU (two extra passes) and then runs as A + ~B + cin.
// The 32-bit result is held until the consumer takes it.
//
// Optional feature macro: ALU_SEQ_SUB_EN
//   defined   : op 4 (SUB) runs through NLO/NHI/LO/HI
//   undefined : op 4 is illegal, NLO/NHI are not built
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op, req_a, req_b, req_cin  operation, operands, carry-in
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_cout, rsp_zero, rsp_err  result and flags
//   alu_a, alu_b, alu_c_in, alu_func       drive to the 16-bit ALU
//   alu_out, alu_c_out                     same-cycle ALU result
// -----------------------------------------------------------------------------
module alu_seq32
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_cin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_cout,
   output logic        rsp_zero,
   output logic        rsp_err,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_c_in,
   output logic [1:0]  alu_func,
   input  logic [15:0] alu_out,
   input  logic        alu_c_out
);

   state_t      state_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic        arith_reg;
   logic [1:0]  func_reg;
   logic [15:0] result_lo_reg;
`ifdef ALU_SEQ_SUB_EN
   logic        cin_reg;
`endif

   logic [31:0] rsp_data_reg;
   logic        rsp_valid_reg;
   logic        rsp_cout_reg;
   logic        rsp_zero_reg;
   logic        rsp_err_reg;
   logic [15:0] alu_a_reg;
   logic [15:0] alu_b_reg;
   logic        alu_c_in_reg;
   logic [1:0]  alu_func_reg;

   // ALU drive registers are loaded on the edge that enters the state using
   // them, so the ALU sees stable operands for the whole pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         arith_reg     <= 1'b0;
         func_reg      <= FUNC_ADD;
         result_lo_reg <= '0;
`ifdef ALU_SEQ_SUB_EN
         cin_reg       <= 1'b0;
`endif
         rsp_data_reg  <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_cout_reg  <= 1'b0;
         rsp_zero_reg  <= 1'b0;
         rsp_err_reg   <= 1'b0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_c_in_reg  <= 1'b0;
         alu_func_reg  <= FUNC_ADD;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  a_reg     <= req_a;
                  b_reg     <= req_b;
                  arith_reg <= op_is_arith(req_op);
                  func_reg  <= op_func(req_op);
`ifdef ALU_SEQ_SUB_EN
                  cin_reg   <= req_cin;
`endif
                  if (!op_legal(req_op)) begin
                     rsp_data_reg  <= '0;
                     rsp_cout_reg  <= 1'b0;
                     rsp_zero_reg  <= 1'b0;
                     rsp_err_reg   <= 1'b1;
                     rsp_valid_reg <= 1'b1;
                     state_reg     <= ST_RESP;
                  end
`ifdef ALU_SEQ_SUB_EN
                  else if (req_op == OP_SUB) begin
                     alu_a_reg    <= '0;
                     alu_b_reg    <= req_b[15:0];
                     alu_c_in_reg <= 1'b0;
                     alu_func_reg <= FUNC_NOTB;
                     state_reg    <= ST_NLO;
                  end
`endif
                  else begin
                     alu_a_reg    <= req_a[15:0];
                     alu_b_reg    <= req_b[15:0];
                     alu_c_in_reg <= op_is_arith(req_op) & req_cin;
                     alu_func_reg <= op_func(req_op);
                     state_reg    <= ST_LO;
                  end
               end
            end
`ifdef ALU_SEQ_SUB_EN
            ST_NLO: begin
               b_reg[15:0]  <= alu_out;
               alu_b_reg    <= b_reg[31:16];
               state_reg    <= ST_NHI;
            end
            ST_NHI: begin
               // Low half of B was inverted last pass; high half arrives now
               b_reg[31:16] <= alu_out;
               alu_a_reg    <= a_reg[15:0];
               alu_b_reg    <= b_reg[15:0];
               alu_c_in_reg <= cin_reg;
               alu_func_reg <= FUNC_ADD;
               state_reg    <= ST_LO;
            end
`endif
            ST_LO: begin
               result_lo_reg <= alu_out;
               alu_a_reg     <= a_reg[31:16];
               alu_b_reg     <= b_reg[31:16];
               alu_c_in_reg  <= arith_reg & alu_c_out;
               alu_func_reg  <= func_reg;
               state_reg     <= ST_HI;
            end
            ST_HI: begin
               rsp_data_reg  <= {alu_out, result_lo_reg};
               rsp_zero_reg  <= ({alu_out, result_lo_reg} == 32'd0);
               rsp_cout_reg  <= arith_reg & alu_c_out;
               rsp_err_reg   <= 1'b0;
               rsp_valid_reg <= 1'b1;
               alu_a_reg     <= '0;
               alu_b_reg     <= '0;
               alu_c_in_reg  <= 1'b0;
               alu_func_reg  <= FUNC_ADD;
               state_reg     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_reg == ST_IDLE);
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_cout  = rsp_cout_reg;
   assign rsp_zero  = rsp_zero_reg;
   assign rsp_err   = rsp_err_reg;
   assign alu_a     = alu_a_reg;
   assign alu_b     = alu_b_reg;
   assign alu_c_in  = alu_c_in_reg;
   assign alu_func  = alu_func_reg;

endmodule

// File: tb/tb_alu_seq32.sv
// -----------------------------------------------------------------------------
// tb_alu_seq32
// Directed bench for alu_seq32 with a behavioural 16-bit ALU as responder.
// Honours ALU_SEQ_SUB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        req_cin = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_cout;
   logic        rsp_zero;
   logic        rsp_err;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_c_in;
   logic [1:0]  alu_func;
   logic [15:0] alu_out;
   logic        alu_c_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_seq32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_cout  (rsp_cout),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c_in  (alu_c_in),
      .alu_func  (alu_func),
      .alu_out   (alu_out),
      .alu_c_out (alu_c_out)
   );

   // Behavioural 16-bit ALU
   always_comb begin
      alu_out   = '0;
      alu_c_out = 1'b0;
      case (alu_func)
         2'b00:   {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_c_in};
         2'b01:   alu_out = alu_a & ~alu_b;
         2'b10:   alu_out = alu_a | alu_b;
         default: alu_out = ~alu_b;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Wait (bounded) for rsp_valid; returns cycle index relative to the accept
   // edge and the ALU carry-in seen in the cycle just before the response.
   task automatic wait_rsp(output int lat, output logic last_cin);
      lat = 0;
      last_cin = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = i;
            break;
         end
         last_cin = alu_c_in;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [31:0] exp_data,
                         input logic exp_cout, input logic exp_zero, input logic exp_err,
                         input int exp_lat, output logic last_cin);
      int lat;
      @(negedge clk);
      check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat, last_cin);
      check({tag, ".lat"},  lat, exp_lat);
      check({tag, ".data"}, rsp_data, exp_data);
      check({tag, ".cout"}, {31'd0, rsp_cout}, {31'd0, exp_cout});
      check({tag, ".zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
      check({tag, ".err"},  {31'd0, rsp_err},  {31'd0, exp_err});
      @(posedge clk);
      @(negedge clk);
      check({tag, ".idle_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, ".idle_alu"}, {alu_a, alu_b[13:0], alu_func}, 32'd0);
      $display("op %0d a=0x%08h b=0x%08h cin=%0b -> data=0x%08h cout=%0b zero=%0b err=%0b lat=%0d",
               op, a, b, cin, rsp_data, rsp_cout, rsp_zero, rsp_err, lat);
   endtask

   initial begin
      logic lc;
      int   lat;

      // Reset state
      #2;
      check("rst.req_ready", {31'd0, req_ready}, 32'd1);
      check("rst.rsp", {28'd0, rsp_valid, rsp_cout, rsp_zero, rsp_err}, 32'd0);
      check("rst.data", rsp_data, 32'd0);
      check("rst.alu", {alu_a, alu_b}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Carry chains low -> high
      run_op("add_chain", 3'd0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 3, lc);
      check("add_chain.hi_cin", {31'd0, lc}, 32'd1);
      run_op("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 3, lc);

`ifdef ALU_SEQ_SUB_EN
      run_op("sub_5_3", 3'd4, 32'd5, 32'd3, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 5, lc);
      run_op("sub_3_5", 3'd4, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 5, lc);
`else
      run_op("sub_off", 3'd4, 32'd5, 32'd3, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, lc);
`endif

      run_op("andn", 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 3, lc);
      check("andn.hi_cin", {31'd0, lc}, 32'd0);
      run_op("or",   3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 3, lc);
      run_op("notb", 3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h00FF00FF, 1'b0, 1'b0, 1'b0, 3, lc);
      run_op("illegal7", 3'd7, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, lc);

      // Back-pressure: response held, new request waits for the handshake
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'h10; req_b = 32'h20; req_cin = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat, lc);
      check("bp.lat", lat, 3);
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'h100; req_b = 32'h1; req_cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp.hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp.hold_data", rsp_data, 32'h30);
         check("bp.req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp.after_valid", {31'd0, rsp_valid}, 32'd0);
      check("bp.after_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat, lc);
      check("bp2.lat", lat, 3);
      check("bp2.data", rsp_data, 32'h101);
      $display("backpressure: second op data=0x%08h lat=%0d", rsp_data, lat);
      @(posedge clk);

      // Reset during HI
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'h12345678; req_b = 32'h1; req_cin = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst.req_ready", {31'd0, req_ready}, 32'd1);
      check("midrst.rsp", {28'd0, rsp_valid, rsp_cout, rsp_zero, rsp_err}, 32'd0);
      check("midrst.data", rsp_data, 32'd0);
      check("midrst.alu", {alu_a, alu_b}, 32'd0);
      check("midrst.alu_ctl", {29'd0, alu_c_in, alu_func}, 32'd0);
      $display("reset mid-op: req_ready=%0b rsp_valid=%0b data=0x%08h", req_ready, rsp_valid, rsp_data);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 3'd0, 32'd1, 32'd1, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 3, lc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
